// File: rtl/uart_arb_pkg.sv
// Shared types and sizing helpers for the two-master UART bus arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RDATA = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam int unsigned UART_ARB_TIMEOUT_DEFAULT = 32'd1024;

  // Stall counter width: enough to hold TIMEOUT_CYCLES, never narrower than one bit.
  function automatic int unsigned arb_cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles + 32'd1);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/uart_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the master not served last.
module uart_arb_rr
  import uart_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt
);

  // Pick the winner from the current requests and the last master served.
  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt = ~last;
    end else begin
      gnt = req[1];
    end
  end

endmodule

// File: rtl/uart_bus_arbiter.sv
// Shares the UART bus slave port between two masters, one registered transaction at a time,
// with round-robin tie breaking and an optional stall timeout.
module uart_bus_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = UART_ARB_TIMEOUT_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] m0_dat_i,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_dat_i,
  input  logic [31:0] m1_adr_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_dat_o,
  output logic [31:0] s_adr_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i
);

  localparam int unsigned    WCW        = arb_cnt_width(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0] WAIT_ONE   = WCW'(32'd1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT_CYCLES - 32'd1);
  localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 32'd0);

  arb_state_t     state_r;
  logic           grant_r;
  logic           last_r;
  logic [WCW-1:0] wait_cnt_r;

  logic [1:0]     req_s;
  logic           gnt_valid_s;
  logic           gnt_s;
  logic           done_s;
  logic           done_err_s;
  logic [31:0]    done_dat_s;

  assign req_s = {m1_stb_i, m0_stb_i};

  uart_arb_rr u_rr (
    .req       (req_s),
    .last      (last_r),
    .gnt_valid (gnt_valid_s),
    .gnt       (gnt_s)
  );

  // Detect the cycle that hands the transaction over to ACK, and what the master will see.
  always_comb begin
    done_s     = 1'b0;
    done_err_s = 1'b0;
    done_dat_s = 32'd0;
    case (state_r)
      ISSUE: begin
        if (s_ack_i) begin
          done_s = s_we_o;
        end else if (TIMEOUT_EN && (wait_cnt_r == WAIT_LAST)) begin
          done_s     = 1'b1;
          done_err_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      RDATA: begin
        done_s     = 1'b1;
        done_dat_s = s_dat_i;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Transaction FSM and the latched slave request.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r    <= IDLE;
      grant_r    <= 1'b0;
      last_r     <= 1'b1;
      wait_cnt_r <= {WCW{1'b0}};
      s_stb_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_adr_o    <= 32'd0;
      s_dat_o    <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            grant_r    <= gnt_s;
            s_adr_o    <= gnt_s ? m1_adr_i : m0_adr_i;
            s_dat_o    <= gnt_s ? m1_dat_i : m0_dat_i;
            s_we_o     <= gnt_s ? m1_we_i  : m0_we_i;
            s_stb_o    <= 1'b1;
            wait_cnt_r <= {WCW{1'b0}};
            state_r    <= ISSUE;
          end else begin
            state_r <= IDLE;
          end
        end
        ISSUE: begin
          if (s_ack_i) begin
            s_stb_o <= 1'b0;
            state_r <= s_we_o ? ACK : RDATA;
          end else begin
            wait_cnt_r <= wait_cnt_r + WAIT_ONE;
            if (done_s) begin
              s_stb_o <= 1'b0;
              state_r <= ACK;
            end else begin
              state_r <= ISSUE;
            end
          end
        end
        RDATA: begin
          state_r <= ACK;
        end
        ACK: begin
          last_r  <= grant_r;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Master-side responses: only the granted master ever sees a non-zero ack/err/dat.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      m0_err_o <= 1'b0;
      m1_err_o <= 1'b0;
      m0_dat_o <= 32'd0;
      m1_dat_o <= 32'd0;
    end else begin
      m0_ack_o <= done_s & ~grant_r;
      m1_ack_o <= done_s & grant_r;
      m0_err_o <= done_err_s & ~grant_r;
      m1_err_o <= done_err_s & grant_r;
      m0_dat_o <= (done_s & ~grant_r) ? done_dat_s : 32'd0;
      m1_dat_o <= (done_s & grant_r) ? done_dat_s : 32'd0;
    end
  end

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Two-master arbiter sharing the single bus slave port of the UART block between the CPU and a second requester (boot loader / debug master). It accepts one transaction at a time from either master, replays it on the UART port with stable registered signals, and returns ack and read data to the winning master. Ties are broken by round-robin, and a programmable timeout bounds how long the UART may stall a write while its TX FIFO is full.

## Interface
- TIMEOUT_CYCLES, 1024: cycles in ISSUE without `s_ack_i` before abort; 0 disables the timeout.
- sys_clk  in  1  single clock, rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- m0_dat_i / m1_dat_i  in  32  master write data.
- m0_adr_i / m1_adr_i  in  32  master address.
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read.
- m0_stb_i / m1_stb_i  in  1  request; held high until ack.
- m0_dat_o / m1_dat_o  out  32  read data, valid while the matching ack is high.
- m0_ack_o / m1_ack_o  out  1  one-cycle completion pulse.
- m0_err_o / m1_err_o  out  1  high with ack when the transaction timed out.
- s_dat_o  out  32  to UART `dat_i`.
- s_adr_o  out  32  to UART `adr_i`.
- s_we_o  out  1  to UART `we_i`.
- s_stb_o  out  1  to UART `stb_i`.
- s_ack_i  in  1  from UART `ack_o` (combinational in the UART).
- s_dat_i  in  32  from UART `dat_o`; valid the cycle after `s_ack_i`.

## Operation
- States: IDLE, ISSUE, RDATA, ACK. Registers: `grant` (0/1), `last` (last master served), `wait_cnt`, latched slave request, `rdata`, `err`.
- IDLE:
  - No `stb` high: stay in IDLE.
  - One master requesting: grant that master.
  - Both requesting: grant `!last`.
  - On grant: latch that master's adr/dat/we into the `s_*` registers, set `s_stb_o=1`, clear `wait_cnt`, then go to ISSUE.
- ISSUE:
  - `s_stb_o` is held high and the `s_*` outputs stay constant.
  - When `s_ack_i=1`: drop `s_stb_o`. A write goes to ACK with `rdata=0`. A read goes to RDATA.
  - Otherwise `wait_cnt++`. If TIMEOUT_CYCLES≠0 and `wait_cnt == TIMEOUT_CYCLES-1`: drop `s_stb_o`, set `err=1`, set `rdata=0`, go to ACK.
- RDATA: capture `s_dat_i` into `rdata`, then go to ACK.
- ACK:
  - `m{grant}_ack_o=1`, `m{grant}_dat_o=rdata`, `m{grant}_err_o=err`.
  - Set `last=grant`, clear `err`, go to IDLE.
- The non-granted master always sees ack, err and dat all at 0.
- A master dropping `stb` mid-transaction has no effect: the latched request completes and ack is still pulsed.
- A master must deassert `stb` on the edge ending its ack cycle. If `stb` is still high in the next IDLE cycle, that is a new request.

## Timing
- Reset (asynchronous): state=IDLE, `last=1` so m0 wins the first tie, every output 0, `wait_cnt=0`, `err=0`.
- Reset asserted in any state aborts immediately. No ack is issued, and `s_stb_o` falls asynchronously.
- Write with immediate slave ack: `stb` sampled in cycle 0, `s_stb_o` high in cycle 1, master ack in cycle 2.
- Read with immediate slave ack: `s_stb_o` in cycle 1, capture in cycle 2, master ack in cycle 3.
- Each cycle of slave stall adds exactly one cycle of latency.
- Throughput: one transaction per 3 cycles for writes, 4 cycles for reads (IDLE is always visited).
- A timeout produces `s_stb_o` high for exactly TIMEOUT_CYCLES cycles, then ack+err in the following cycle.
- `s_stb_o` is never high for two back-to-back transactions without an intervening low cycle. This guarantees the UART's edge-based `tx_wr`/`rx_wr` logic sees distinct accesses.

## Structure
- Package `uart_arb_pkg`:
  - state enum (IDLE, ISSUE, RDATA, ACK), 2-bit encoding;
  - `UART_ARB_TIMEOUT_DEFAULT = 1024`;
  - `wait_cnt` width = `$clog2(TIMEOUT_CYCLES+1)`, minimum 1.
- Sub-module `uart_arb_rr`: combinational 2-way round-robin picker, taking `req[1:0]` and `last` and producing `gnt_valid` and `gnt`. The FSM and datapath stay in the top module.

## Test plan
- Write: m0 write, adr 0, dat 0x41; UART acks at once → cycle 1: `s_stb_o=1`, `s_dat_o=0x41`, `s_we_o=1`; cycle 2: `m0_ack_o=1`, `m0_err_o=0`; cycle 3 back in IDLE.
- Read: m1 read, adr 1; `s_ack_i` in cycle 1; `s_dat_i=0x00000036` in cycle 2 → cycle 3: `m1_ack_o=1`, `m1_dat_o=0x36`; `m0_ack_o` stays 0 throughout.
- Arbitration: both masters hold `stb` continuously after reset, 4 transactions → grants m0, m1, m0, m1; each ack pulse lasts exactly one cycle.
- Timeout: TIMEOUT_CYCLES=16, m0 write, `s_ack_i` held 0 → `s_stb_o` high 16 cycles, then `m0_ack_o=1`, `m0_err_o=1`, `m0_dat_o=0`.
- Stall: `s_ack_i` delayed 5 cycles (under the timeout) → `m0_ack_o` in cycle 7, `err=0`, `s_*` outputs stable throughout ISSUE.
- Reset mid-ISSUE: assert `sys_rst` for 1 cycle → all outputs 0 immediately, no ack; a following m1 request is granted normally.
